// File: rtl/one_bit_predictor_if.sv
// Fetch/resolve side bundle for the 1-bit branch predictor.
// The master drives lookup/training, and the slave returns the prediction and statistics.
interface one_bit_predictor_if #(
  parameter int ADDR_W = 3,
  parameter int CNT_W  = 8
);
  logic [ADDR_W-1:0] addr;
  logic              outcome;
  logic              update;
  logic              pred;
  logic              miss;
  logic [CNT_W-1:0]  branch_count;
  logic [CNT_W-1:0]  miss_count;

  modport master (
    output addr, outcome, update,
    input  pred, miss, branch_count, miss_count
  );

  modport slave (
    input  addr, outcome, update,
    output pred, miss, branch_count, miss_count
  );
endinterface

// File: rtl/one_bit_predictor.sv
// 1-bit branch direction predictor: a table of last-outcome bits with a combinational lookup,
// a registered mispredict flag and saturating update/miss statistics.

module one_bit_predictor_entry #(
  parameter logic INIT_PRED = 1'b0
) (
  input  logic clk,
  input  logic init,
  input  logic we,
  input  logic d,
  output logic q
);
  always_ff @(posedge clk or posedge init) begin
    if (init)    q <= INIT_PRED;
    else if (we) q <= d;
  end
endmodule

module one_bit_predictor #(
  parameter int   ADDR_W    = 3,
  parameter int   CNT_W     = 8,
  parameter logic INIT_PRED = 1'b0
) (
  input  logic                 clk,
  input  logic                 init,
  one_bit_predictor_if.slave   bus
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0] tbl;
  logic [DEPTH-1:0] we;
  logic             cur;
  logic             mispred;
  logic             miss_q;
  logic [CNT_W-1:0] bcnt_q;
  logic [CNT_W-1:0] mcnt_q;

  // Exactly one entry is write-enabled per update, so the other entries never move.
  always_comb begin
    we = '0;
    for (int i = 0; i < DEPTH; i++)
      we[i] = bus.update && (bus.addr == ADDR_W'(i));
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    one_bit_predictor_entry #(.INIT_PRED(INIT_PRED)) u_entry (
      .clk  (clk),
      .init (init),
      .we   (we[gi]),
      .d    (bus.outcome),
      .q    (tbl[gi])
    );
  end

  assign cur     = tbl[bus.addr];
  assign mispred = cur != bus.outcome;

  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      miss_q <= 1'b0;
      bcnt_q <= '0;
      mcnt_q <= '0;
    end else begin
      miss_q <= bus.update && mispred;
      if (bus.update && (bcnt_q != '1))
        bcnt_q <= bcnt_q + 1'b1;
      if (bus.update && mispred && (mcnt_q != '1))
        mcnt_q <= mcnt_q + 1'b1;
    end
  end

  assign bus.pred         = cur;
  assign bus.miss         = miss_q;
  assign bus.branch_count = bcnt_q;
  assign bus.miss_count   = mcnt_q;
endmodule

// File: tb/tb_one_bit_predictor.sv
// Directed self-checking bench for one_bit_predictor.
module tb_one_bit_predictor;
  logic clk = 1'b0;
  logic init;
  int   ntests = 0;
  int   nfail  = 0;

  one_bit_predictor_if #(.ADDR_W(3), .CNT_W(8)) bus ();

  one_bit_predictor #(.ADDR_W(3), .CNT_W(8), .INIT_PRED(1'b0)) dut (
    .clk  (clk),
    .init (init),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Drive one clock edge from the negedge, then sample 1 time unit after the posedge.
  task automatic step(input logic [2:0] a, input logic o, input logic u);
    @(negedge clk);
    bus.addr    = a;
    bus.outcome = o;
    bus.update  = u;
    @(posedge clk);
    #1;
    bus.update = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    init = 1'b1;
    #2;
    init = 1'b0;
  endtask

  task automatic test_reset();
    init = 1'b1;
    bus.update = 1'b0;
    bus.outcome = 1'b0;
    for (int a = 0; a < 8; a++) begin
      bus.addr = 3'(a);
      #1;
      ntests++;
      if (bus.pred !== 1'b0) begin
        nfail++;
        $display("FAIL reset_pred addr=%0d got=%b exp=0", a, bus.pred);
      end
    end
    ntests++;
    if (bus.miss !== 1'b0 || bus.branch_count !== 8'd0 || bus.miss_count !== 8'd0) begin
      nfail++;
      $display("FAIL reset_state got miss=%b bc=%0d mc=%0d exp 0/0/0", bus.miss, bus.branch_count, bus.miss_count);
    end
    @(negedge clk);
    init = 1'b0;
  endtask

  task automatic test_train_taken();
    step(3'd1, 1'b1, 1'b1);
    ntests++;
    if (bus.miss !== 1'b1 || bus.pred !== 1'b1 || bus.branch_count !== 8'd1 || bus.miss_count !== 8'd1) begin
      nfail++;
      $display("FAIL train_first got miss=%b pred=%b bc=%0d mc=%0d exp 1/1/1/1", bus.miss, bus.pred, bus.branch_count, bus.miss_count);
    end
    step(3'd1, 1'b1, 1'b1);
    ntests++;
    if (bus.miss !== 1'b0 || bus.branch_count !== 8'd2 || bus.miss_count !== 8'd1) begin
      nfail++;
      $display("FAIL train_repeat got miss=%b bc=%0d mc=%0d exp 0/2/1", bus.miss, bus.branch_count, bus.miss_count);
    end
    // An idle edge must clear the one-cycle miss pulse.
    step(3'd1, 1'b0, 1'b0);
    ntests++;
    if (bus.miss !== 1'b0 || bus.pred !== 1'b1 || bus.branch_count !== 8'd2) begin
      nfail++;
      $display("FAIL idle_hold got miss=%b pred=%b bc=%0d exp 0/1/2", bus.miss, bus.pred, bus.branch_count);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] pat;
    logic [3:0] exp_miss;
    pat      = 4'b0011;   // bit0 first: 1,1,0,0
    exp_miss = 4'b0101;   // 1,0,1,0
    do_reset();
    for (int k = 0; k < 4; k++) begin
      step(3'd1, pat[k], 1'b1);
      ntests++;
      if (bus.miss !== exp_miss[k]) begin
        nfail++;
        $display("FAIL flip_miss step=%0d got=%b exp=%b", k, bus.miss, exp_miss[k]);
      end
    end
    ntests++;
    if (bus.pred !== 1'b0 || bus.miss_count !== 8'd2 || bus.branch_count !== 8'd4) begin
      nfail++;
      $display("FAIL flip_final got pred=%b mc=%0d bc=%0d exp 0/2/4", bus.pred, bus.miss_count, bus.branch_count);
    end
  endtask

  task automatic test_isolation();
    step(3'd3, 1'b1, 1'b1);
    ntests++;
    if (bus.pred !== 1'b1 || bus.miss !== 1'b1 || bus.branch_count !== 8'd5 || bus.miss_count !== 8'd3) begin
      nfail++;
      $display("FAIL iso_train got pred=%b miss=%b bc=%0d mc=%0d exp 1/1/5/3", bus.pred, bus.miss, bus.branch_count, bus.miss_count);
    end
    for (int a = 0; a < 8; a++) begin
      if (a == 3) continue;
      bus.addr = 3'(a);
      #1;
      ntests++;
      if (bus.pred !== 1'b0) begin
        nfail++;
        $display("FAIL iso_other addr=%0d got=%b exp=0", a, bus.pred);
      end
    end
    step(3'd5, 1'b1, 1'b0);
    ntests++;
    if (bus.pred !== 1'b0 || bus.miss !== 1'b0 || bus.branch_count !== 8'd5 || bus.miss_count !== 8'd3) begin
      nfail++;
      $display("FAIL iso_noupdate got pred=%b miss=%b bc=%0d mc=%0d exp 0/0/5/3", bus.pred, bus.miss, bus.branch_count, bus.miss_count);
    end
  endtask

  task automatic test_midrun_reset();
    @(negedge clk);
    bus.addr = 3'd3;
    #1;
    ntests++;
    if (bus.pred !== 1'b1) begin
      nfail++;
      $display("FAIL prereset_pred got=%b exp=1", bus.pred);
    end
    init = 1'b1;
    #1;
    ntests++;
    if (bus.pred !== 1'b0 || bus.branch_count !== 8'd0 || bus.miss_count !== 8'd0 || bus.miss !== 1'b0) begin
      nfail++;
      $display("FAIL midrun_reset got pred=%b bc=%0d mc=%0d miss=%b exp 0/0/0/0", bus.pred, bus.branch_count, bus.miss_count, bus.miss);
    end
    // An update edge while init is held must be ignored.
    bus.addr = 3'd4;
    bus.outcome = 1'b1;
    bus.update = 1'b1;
    @(posedge clk);
    #1;
    ntests++;
    if (bus.pred !== 1'b0 || bus.branch_count !== 8'd0 || bus.miss !== 1'b0) begin
      nfail++;
      $display("FAIL reset_ignores_update got pred=%b bc=%0d miss=%b exp 0/0/0", bus.pred, bus.branch_count, bus.miss);
    end
    @(negedge clk);
    bus.update = 1'b0;
    init = 1'b0;
    // The first edge after init falls accepts an update.
    step(3'd4, 1'b1, 1'b1);
    ntests++;
    if (bus.pred !== 1'b1 || bus.branch_count !== 8'd1 || bus.miss_count !== 8'd1) begin
      nfail++;
      $display("FAIL post_reset_update got pred=%b bc=%0d mc=%0d exp 1/1/1", bus.pred, bus.branch_count, bus.miss_count);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int k = 0; k < 300; k++) begin
      step(3'd2, ~k[0], 1'b1);
      if (k == 253) begin
        ntests++;
        if (bus.branch_count !== 8'd254 || bus.miss_count !== 8'd254) begin
          nfail++;
          $display("FAIL sat_254 got bc=%0d mc=%0d exp 254/254", bus.branch_count, bus.miss_count);
        end
      end
      if (k == 254) begin
        ntests++;
        if (bus.branch_count !== 8'd255 || bus.miss_count !== 8'd255) begin
          nfail++;
          $display("FAIL sat_255 got bc=%0d mc=%0d exp 255/255", bus.branch_count, bus.miss_count);
        end
      end
    end
    ntests++;
    if (bus.branch_count !== 8'd255 || bus.miss_count !== 8'd255 || bus.miss !== 1'b1) begin
      nfail++;
      $display("FAIL sat_hold got bc=%0d mc=%0d miss=%b exp 255/255/1", bus.branch_count, bus.miss_count, bus.miss);
    end
  endtask

  initial begin
    test_reset();
    test_train_taken();
    test_back_to_back();
    test_isolation();
    test_midrun_reset();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule

// File: doc/one_bit_predictor.md
# one_bit_predictor

Branch-direction predictor built from a table of 1-bit history entries indexed by a branch address. It gives a combinational taken/not-taken prediction for the presented address. On each update it records the resolved outcome, flags a misprediction and maintains saturating branch and miss statistics. It sits beside the fetch stage: fetch reads `pred`, and the resolve stage drives `outcome`/`update`.

## Interface
- `ADDR_W`, default 3: index width; table depth is 2^ADDR_W entries (8 by default).
- `CNT_W`, default 8: width of the statistics counters.
- `INIT_PRED`, default 1'b0: value loaded into every entry on reset (0 = not-taken).

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  rising-edge clock.
- `init`  in  1  asynchronous, active-high reset.
- `addr`  in  ADDR_W  branch index, used for both lookup and update.
- `outcome`  in  1  resolved direction of the branch at `addr` (1 = taken); sampled only when `update`=1.
- `update`  in  1  write strobe; when high at a rising edge, the entry at `addr` is trained.
- `pred`  out  1  current prediction, `table[addr]`; combinational.
- `miss`  out  1  registered flag; high for the one cycle after an update that mispredicted.
- `branch_count`  out  CNT_W  number of updates, saturating.
- `miss_count`  out  CNT_W  number of mispredicted updates, saturating.

## Operation
- Storage: 2^ADDR_W single-bit registers, `table[i]`.
- Lookup: `pred = table[addr]`, purely combinational, with no clock latency.
- Update at a rising edge with `update`=1:
  - `miss <= (table[addr] != outcome)`, using the pre-edge table value.
  - `table[addr] <= outcome`. This is the 1-bit rule: the entry predicts whatever the branch did last time.
  - `branch_count` increments by 1; it holds at all-ones once saturated.
  - `miss_count` increments by 1 only on a mispredict; it also saturates at all-ones.
- Rising edge with `update`=0:
  - table and counters hold.
  - `miss <= 0`.
- Only the addressed entry changes; the other entries are never disturbed.
- Reset (`init`=1, asynchronous, overriding the clock):
  - every `table[i]` = INIT_PRED.
  - `miss` = 0, `branch_count` = 0, `miss_count` = 0.
  - therefore `pred` = INIT_PRED for any `addr`.
  - the block stays in this state for as long as `init` is high.
- `addr` and `outcome` are don't-care when `update`=0.
- Out-of-range addresses cannot occur, because the table depth is a full power of two.

## Timing
- `pred` follows `addr` combinationally. After an update edge, the new entry value appears on `pred` within the same cycle, once the register output settles.
- `miss` has one cycle of latency: it is valid in the cycle after the update edge and lasts exactly one cycle per update.
- Back-to-back updates to the same address are legal. The second update compares against the value written by the first.
- Reset asserted mid-operation clears all state immediately, without waiting for a clock edge. An update edge coinciding with asserted `init` is ignored.
- Reset deassertion is expected to be synchronized externally. The first update is accepted on the first rising edge after `init` falls.

## Test plan
1. Reset:
   - stimulus: assert `init`, then sweep `addr` 0..7.
   - required: `pred`=0 at every address; `miss`=0; both counters = 0.
2. Train taken at `addr`=1:
   - stimulus: update with `outcome`=1.
   - required: next cycle `miss`=1, `pred`=1, `branch_count`=1, `miss_count`=1.
   - stimulus: repeat the update with `outcome`=1.
   - required: `miss`=0, `branch_count`=2, `miss_count`=1.
3. Direction flip at `addr`=1 (pattern 1,1,0,0):
   - required `miss` sequence: 1,0,1,0.
   - required final values: `pred`=0, `miss_count`=2, `branch_count`=4.
4. Isolation:
   - stimulus: train `addr`=3 to taken.
   - required: `pred` stays 0 at `addr`=0,1,2,4..7.
   - stimulus: with `update`=0, drive `outcome`=1 at `addr`=5.
   - required: `pred` at 5 stays 0 and counters are unchanged.
5. Saturation:
   - stimulus: 300 alternating-outcome updates at `addr`=2.
   - required: both `branch_count` and `miss_count` hold at 255.
6. Mid-run reset:
   - stimulus: after test 4, pulse `init` between clock edges.
   - required: `pred` at `addr`=3 drops to 0 immediately, and both counters drop to 0 before the next edge.
